// File: rtl/tempsense_vdac_sar_ctrl.sv
// Sequential controller for the tempsense VDAC: drives the DAC code and enable,
// synchronises the comparator and runs either a binary-search SAR conversion
// or continuous +/-1 LSB tracking. Every output comes straight from a flop.
module tempsense_vdac_sar_ctrl #(
  parameter int BITWIDTH = 6,
  parameter int SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                comp_in,
  output logic [BITWIDTH-1:0] dac_data,
  output logic                dac_enable,
  output logic                busy,
  output logic                done,
  output logic [BITWIDTH-1:0] result,
  output logic                result_valid
);

  localparam int IDX_W = $clog2(BITWIDTH);
  localparam logic [BITWIDTH-1:0] MSB_CODE = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic [BITWIDTH-1:0] ONE_CODE = BITWIDTH'(1);
  localparam logic [BITWIDTH-1:0] MAX_CODE = {BITWIDTH{1'b1}};
  localparam logic [BITWIDTH-1:0] MIN_CODE = {BITWIDTH{1'b0}};

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [SETTLE_W-1:0] cnt_r, cnt_s;
  logic [SETTLE_W-1:0] settle_r, settle_s;
  logic                mode_r, mode_s;
  logic [IDX_W-1:0]    bit_r, bit_s;
  logic                sync1_r, sync2_r;
  logic [BITWIDTH-1:0] dac_data_s, result_s;
  logic                dac_enable_s, busy_s, done_s, result_valid_s;
  logic [BITWIDTH-1:0] cur_mask_s, trial_mask_s, sar_keep_s, track_code_s;

  // Two-flop synchroniser for the asynchronous comparator decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= comp_in;
      sync2_r <= sync1_r;
    end
  end

  // Decision datapath: resolve the SAR trial bit and the saturating tracking step.
  always_comb begin
    cur_mask_s   = ONE_CODE << bit_r;
    trial_mask_s = ONE_CODE << (bit_r - IDX_W'(1));
    sar_keep_s   = sync2_r ? dac_data : (dac_data & ~cur_mask_s);
    track_code_s = dac_data;
    if (sync2_r) begin
      track_code_s = (dac_data == MAX_CODE) ? MAX_CODE : (dac_data + ONE_CODE);
    end else begin
      track_code_s = (dac_data == MIN_CODE) ? MIN_CODE : (dac_data - ONE_CODE);
    end
  end

  // Next-state and next-output logic; stop always takes priority over a decision.
  always_comb begin
    state_s        = state_r;
    cnt_s          = cnt_r;
    settle_s       = settle_r;
    mode_s         = mode_r;
    bit_s          = bit_r;
    dac_data_s     = dac_data;
    dac_enable_s   = dac_enable;
    busy_s         = busy;
    done_s         = 1'b0;
    result_s       = result;
    result_valid_s = result_valid;
    case (state_r)
      IDLE: begin
        dac_enable_s = 1'b0;
        busy_s       = 1'b0;
        if (start && !stop) begin
          state_s      = SETTLE;
          mode_s       = mode;
          settle_s     = settle_cycles;
          cnt_s        = settle_cycles;
          dac_enable_s = 1'b1;
          busy_s       = 1'b1;
          if (!mode) begin
            dac_data_s = MSB_CODE;
            bit_s      = IDX_W'(BITWIDTH - 1);
          end else begin
            dac_data_s = result_valid ? result : MSB_CODE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETTLE: begin
        if (stop) begin
          state_s      = IDLE;
          busy_s       = 1'b0;
          dac_enable_s = 1'b0;
        end else if (cnt_r != {SETTLE_W{1'b0}}) begin
          cnt_s = cnt_r - SETTLE_W'(1);
        end else if (!mode_r) begin
          if (bit_r != {IDX_W{1'b0}}) begin
            dac_data_s = sar_keep_s | trial_mask_s;
            bit_s      = bit_r - IDX_W'(1);
            cnt_s      = settle_r;
          end else begin
            dac_data_s     = sar_keep_s;
            result_s       = sar_keep_s;
            done_s         = 1'b1;
            result_valid_s = 1'b1;
            state_s        = IDLE;
            busy_s         = 1'b0;
            dac_enable_s   = 1'b0;
          end
        end else begin
          dac_data_s     = track_code_s;
          result_s       = track_code_s;
          done_s         = 1'b1;
          result_valid_s = 1'b1;
          cnt_s          = settle_r;
        end
      end
      default: begin
        state_s      = IDLE;
        busy_s       = 1'b0;
        dac_enable_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= {SETTLE_W{1'b0}};
      settle_r     <= {SETTLE_W{1'b0}};
      mode_r       <= 1'b0;
      bit_r        <= {IDX_W{1'b0}};
      dac_data     <= {BITWIDTH{1'b0}};
      dac_enable   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= {BITWIDTH{1'b0}};
      result_valid <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      settle_r     <= settle_s;
      mode_r       <= mode_s;
      bit_r        <= bit_s;
      dac_data     <= dac_data_s;
      dac_enable   <= dac_enable_s;
      busy         <= busy_s;
      done         <= done_s;
      result       <= result_s;
      result_valid <= result_valid_s;
    end
  end

endmodule

// File: doc/tempsense_vdac_sar_ctrl.md
Name: tempsense_vdac_sar_ctrl

Overview:
Parametrised sequential controller for the tempsense VDAC. It generates the BITWIDTH-bit DAC code and enable, and synchronises the analog comparator decision. It supports two modes: binary-search SAR conversion and continuous ±1-LSB tracking. It sits between the digital readout logic and the VDAC/comparator pair. The VDAC output rises monotonically with the unsigned value of dac_data, including the 011..1 -> 100..0 transition.

Parameters:
BITWIDTH, 6, width of the DAC code and result; legal range 2..16.
SETTLE_W, 4, width of the settle_cycles input.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  begin operation; sampled only in IDLE
stop  input  1  abort SAR or end tracking; wins over start
mode  input  1  0 = SAR, 1 = tracking; sampled with start
settle_cycles  input  SETTLE_W  settle time S per step; sampled with start
comp_in  input  1  asynchronous comparator output; 1 = sensor voltage above VDAC output
dac_data  output  BITWIDTH  code driven to the VDAC
dac_enable  output  1  VDAC enable
busy  output  1  high outside IDLE
done  output  1  one-cycle pulse when result is updated
result  output  BITWIDTH  last completed code
result_valid  output  1  set on first done; cleared only by reset

Behaviour:
- Reset (asynchronous, immediate, no clock edge needed): state IDLE; dac_data, result, counters = 0; dac_enable, busy, done, result_valid = 0; synchroniser flops = 0.
- comp_in passes through a 2-flop synchroniser to give comp_s. Decisions use only comp_s. Bench and users must choose S >= 2; this is not enforced.
- All outputs are registered. States: IDLE, SETTLE.
- IDLE:
  - dac_enable = 0; dac_data holds its last value.
  - At an edge with start=1 and stop=0: latch mode, latch S, enter SETTLE with the settle counter loaded to S, dac_enable=1, busy=1.
  - At that same edge dac_data is loaded as follows. SAR: 100..0, bit index = MSB. Tracking: result if result_valid, else 100..0.
- SETTLE:
  - The counter decrements each cycle. In the cycle where counter==0, comp_s is evaluated and the decision is registered at that edge.
  - Each step therefore lasts S+1 cycles.
- SAR decision for the current bit i:
  - If comp_s=1, keep bit i; else clear it.
  - If i>0: set bit i-1 in dac_data, reload the counter.
  - If i==0: result <= final code; done <= 1 for one cycle; result_valid <= 1; state <= IDLE; busy, dac_enable <= 0.
  - done is visible after edge BITWIDTH*(S+1) counted from the start edge (the start edge is edge 0).
- Tracking decision:
  - comp_s=1: code+1, saturating at all-ones. comp_s=0: code-1, saturating at 0.
  - The new code is written to both dac_data and result. done pulses every step, result_valid <= 1, counter reloads.
  - Tracking runs until stop.
- stop in SETTLE: at the next edge go to IDLE with busy=0 and dac_enable=0. result and result_valid are unchanged and there is no done. If stop coincides with a decision edge, stop wins and the decision is discarded.
- start while busy is ignored. Changes to mode or settle_cycles while busy are ignored.
- S=0 is legal: one-cycle steps using a possibly stale comp_s. Behaviour must remain deterministic.
- Width rules: all arithmetic is unsigned and BITWIDTH-wide. The settle counter is SETTLE_W wide.

Test Plan:
- SAR, BITWIDTH=6, S=3, comparator model comp_in = (dac_data <= 43) -> trial codes 32, 48, 40, 44, 42, 43; result=43 (0x2B), done pulse after edge 24, busy low the same cycle, result_valid=1.
- SAR boundaries: comp_in always 1 -> result=63. comp_in always 0 -> result=0. Both must show exactly one done pulse each.
- Tracking from result=43, S=3, model comp_in = (dac_data <= 46) -> result sequence 44, 45, 46, 47, 46, 47…, done every 4 cycles. With comp_in always 1 from 62, the sequence is 63, 63, 63 (saturation).
- stop asserted 10 cycles into a SAR conversion -> busy=0 and dac_enable=0 after the next edge, no done, result keeps its previous value. start and stop asserted together in IDLE -> state stays IDLE.
- reset asserted mid-conversion between clock edges -> dac_data, result, busy, dac_enable, done, result_valid all 0 immediately. After release, a fresh start converts correctly.
- start pulsed while busy, and mode/settle_cycles toggled mid-conversion -> no effect on the step timing or the result of the running operation.
